// File: rtl/ntt_stage_ctrl.sv
// ntt_stage_ctrl: address/sequence controller for an in-place radix-2 NTT.
// Walks NUM_STAGES stages of N/2 butterflies each. For every butterfly it
// issues the top/bottom operand addresses and the twiddle index. A valid
// shift register tracks pairs through the BF_LATENCY-deep butterfly and
// produces next_pair, and done on the final pair.
// Optional feature: define NTT_STAGE_GAP_EN to insert BF_LATENCY idle cycles
// between stages. This keeps stage s+1 from reading data that stage s has
// not yet written back.
module ntt_stage_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int BF_LATENCY = 3,
    localparam int STW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    output logic [NUM_STAGES-1:0] rd_addr_top,
    output logic [NUM_STAGES-1:0] rd_addr_bot,
    output logic [NUM_STAGES-2:0] tw_addr,
    output logic [STW-1:0]        stage,
    output logic                  rd_valid,
    output logic                  next_pair,
    output logic                  busy,
    output logic                  done
);

    localparam int JW = NUM_STAGES - 1;
    localparam logic [JW-1:0]         J_LAST    = {JW{1'b1}};
    localparam logic [STW-1:0]        S_LAST    = STW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ONE_N     = NUM_STAGES'(1);
    localparam logic [JW-1:0]         ONE_J     = JW'(1);
    localparam logic [BF_LATENCY-1:0] PIPE_LAST = BF_LATENCY'(1) << (BF_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic [STW-1:0]          stage_q, stage_d;
    logic [NUM_STAGES-1:0]   top_q, top_d, bot_q, bot_d;
    logic [NUM_STAGES-2:0]   tw_q, tw_d;
    logic [STW-1:0]          stg_q, stg_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [BF_LATENCY-1:0]   pipe_q, pipe_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    issue_s;

    // Address generation for the pair (stage_q, j_q)
    logic [JW-1:0]           mask_s;
    logic [JW-1:0]           k_s;
    logic [NUM_STAGES-1:0]   half_s;
    logic [NUM_STAGES-1:0]   top_s;
    logic [NUM_STAGES-1:0]   bot_s;
    logic [STW-1:0]          tw_sh_s;
    logic [NUM_STAGES-2:0]   tw_s;

`ifdef NTT_STAGE_GAP_EN
    localparam int GW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(BF_LATENCY - 1);
    logic [GW-1:0] gap_q, gap_d;
`endif

    // Butterfly addressing: the upper j bits select the group and the lower s bits the offset.
    // The group bits are shifted up by one to skip the bottom half of each group.
    always_comb begin
        half_s  = ONE_N << stage_q;
        mask_s  = (ONE_J << stage_q) - ONE_J;
        k_s     = j_q & mask_s;
        top_s   = {(j_q & ~mask_s), 1'b0} | {1'b0, k_s};
        bot_s   = top_s | half_s;
        tw_sh_s = S_LAST - stage_q;
        tw_s    = k_s << tw_sh_s;
    end

    // The valid pipe keeps shifting during stall so in-flight pairs still retire
    always_comb begin
        pipe_d = (pipe_q << 1) | BF_LATENCY'(rd_valid_q);
    end

    // Next-state logic: sequencing, counter advance and output loading
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        stage_d    = stage_q;
        top_d      = top_q;
        bot_d      = bot_q;
        tw_d       = tw_q;
        stg_d      = stg_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        issue_s    = 1'b0;
`ifdef NTT_STAGE_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    issue_s = ~stall;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                issue_s = ~stall;
            end
            GAP: begin
`ifdef NTT_STAGE_GAP_EN
                if (gap_q == GAP_LAST) begin
                    state_d = ISSUE;
                    gap_d   = '0;
                end else begin
                    gap_d   = gap_q + GW'(1);
                end
`else
                state_d = ISSUE;
`endif
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                    stage_d = '0;
                    j_d     = '0;
                end else if (pipe_d == PIPE_LAST) begin
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue_s) begin
            top_d      = top_s;
            bot_d      = bot_s;
            tw_d       = tw_s;
            stg_d      = stage_q;
            rd_valid_d = 1'b1;
            if (j_q == J_LAST) begin
                j_d = '0;
                if (stage_q == S_LAST) begin
                    state_d = DRAIN;
                end else begin
                    stage_d = stage_q + STW'(1);
`ifdef NTT_STAGE_GAP_EN
                    state_d = GAP;
                    gap_d   = '0;
`else
                    state_d = ISSUE;
`endif
                end
            end else begin
                j_d = j_q + ONE_J;
            end
        end else begin
            rd_valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            j_q        <= '0;
            stage_q    <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            tw_q       <= '0;
            stg_q      <= '0;
            rd_valid_q <= 1'b0;
            pipe_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            stage_q    <= stage_d;
            top_q      <= top_d;
            bot_q      <= bot_d;
            tw_q       <= tw_d;
            stg_q      <= stg_d;
            rd_valid_q <= rd_valid_d;
            pipe_q     <= pipe_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef NTT_STAGE_GAP_EN
    // Inter-stage gap counter
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign rd_addr_top = top_q;
    assign rd_addr_bot = bot_q;
    assign tw_addr     = tw_q;
    assign stage       = stg_q;
    assign rd_valid    = rd_valid_q;
    assign next_pair   = pipe_q[BF_LATENCY-1];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// tb_ntt_stage_ctrl: randomized and directed bench for ntt_stage_ctrl.
// The reference model precomputes the butterfly address table arithmetically.
// It then predicts each cycle from counts of issued pairs, stall and gap time.
module tb_ntt_stage_ctrl;

    localparam int NS   = 4;
    localparam int L    = 3;
    localparam int HALF = 8;
    localparam int NP   = 32;
`ifdef NTT_STAGE_GAP_EN
    localparam int GAPC = L;
`else
    localparam int GAPC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, stall;
    logic [3:0]  rd_addr_top, rd_addr_bot;
    logic [2:0]  tw_addr;
    logic [1:0]  stage;
    logic        rd_valid, next_pair, busy, done;

    ntt_stage_ctrl #(.NUM_STAGES(NS), .BF_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .rd_addr_top(rd_addr_top), .rd_addr_bot(rd_addr_bot),
        .tw_addr(tw_addr), .stage(stage), .rd_valid(rd_valid),
        .next_pair(next_pair), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // reference table
    int t_top [NP];
    int t_bot [NP];
    int t_tw  [NP];
    int t_stg [NP];

    // model state and expected outputs for the upcoming cycle
    bit m_active, m_done_pend;
    int m_issued, m_gap, m_np_cnt;
    bit vh [L];
    logic e_valid, e_np, e_done, e_busy;
    int e_top, e_bot, e_tw, e_stg;

    // observed tallies
    int o_valid, o_np, o_done, o_done_cyc, o_first_cyc;
    int o_top [NP];
    int o_bot [NP];
    int o_tw  [NP];
    int o_stg [NP];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    endtask

    task automatic clear_tally();
        o_valid = 0; o_np = 0; o_done = 0; o_done_cyc = -1; o_first_cyc = -1;
    endtask

    task automatic model_step(input logic st, input logic sl, input logic rs);
        if (rs) begin
            m_active = 0; m_done_pend = 0; m_np_cnt = 0; m_issued = 0; m_gap = 0;
            for (int i = 0; i < L; i++) vh[i] = 0;
            e_valid = 0; e_np = 0; e_done = 0; e_busy = 0;
            e_top = 0; e_bot = 0; e_tw = 0; e_stg = 0;
            return;
        end
        if (!m_active && st) begin
            m_active = 1; m_issued = 0; m_gap = 0; m_np_cnt = 0;
        end
        if (m_done_pend) begin
            m_active = 0; m_done_pend = 0;
        end
        e_valid = 0;
        if (m_active && m_issued < NP) begin
            if (m_gap > 0) m_gap--;
            else if (!sl) begin
                e_valid = 1;
                e_top = t_top[m_issued]; e_bot = t_bot[m_issued];
                e_tw = t_tw[m_issued]; e_stg = t_stg[m_issued];
                m_issued++;
                if (GAPC > 0 && m_issued % HALF == 0 && m_issued < NP) m_gap = GAPC;
            end
        end
        e_np = vh[L-1];
        for (int i = L - 1; i > 0; i--) vh[i] = vh[i-1];
        vh[0] = e_valid;
        e_done = 0;
        if (e_np) begin
            m_np_cnt++;
            if (m_np_cnt == NP) begin
                e_done = 1; m_done_pend = 1;
            end
        end
        e_busy = m_active;
    endtask

    task automatic observe();
        @(negedge clk);
        cyc++;
        check_eq("rd_valid", rd_valid, e_valid);
        check_eq("next_pair", next_pair, e_np);
        check_eq("done", done, e_done);
        check_eq("busy", busy, e_busy);
        check_eq("rd_addr_top", rd_addr_top, e_top);
        check_eq("rd_addr_bot", rd_addr_bot, e_bot);
        check_eq("tw_addr", tw_addr, e_tw);
        check_eq("stage", stage, e_stg);
        if (rd_valid === 1'b1) begin
            if (o_valid == 0) o_first_cyc = cyc;
            if (o_valid < NP) begin
                o_top[o_valid] = rd_addr_top; o_bot[o_valid] = rd_addr_bot;
                o_tw[o_valid] = tw_addr; o_stg[o_valid] = stage;
            end
            o_valid++;
        end
        if (next_pair === 1'b1) o_np++;
        if (done === 1'b1) begin
            o_done++; o_done_cyc = cyc;
        end
    endtask

    task automatic tick(input logic st, input logic sl, input logic rs);
        start = st; stall = sl; reset = rs;
        model_step(st, sl, rs);
        observe();
    endtask

    task automatic run_until_idle(input int budget);
        for (int k = 0; k < budget && m_active; k++) tick(1'b0, 1'b0, 1'b0);
        check_eq("drain_budget", {31'd0, m_active}, 32'd0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    int t0;
    int n6;

    initial begin
        for (int s = 0; s < NS; s++) begin
            for (int j = 0; j < HALF; j++) begin
                int half, g, k;
                half = 1 << s;
                g = j / half;
                k = j % half;
                t_top[s*HALF+j] = g * 2 * half + k;
                t_bot[s*HALF+j] = g * 2 * half + k + half;
                t_tw[s*HALF+j]  = k * (1 << (NS - 1 - s));
                t_stg[s*HALF+j] = s;
            end
        end
        clear_tally();

        // reset state
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("reset_busy", busy, 32'd0);

        // plain transform
        clear_tally();
        t0 = cyc;
        tick(1'b1, 1'b0, 1'b0);
        run_until_idle(100);
        check_eq("s1_nvalid", o_valid, NP);
        check_eq("s1_ndone", o_done, 1);
        check_eq("s1_first_lat", o_first_cyc - t0, 1);
        check_eq("s1_done_lat", o_done_cyc - t0, 35 + 3 * GAPC);
        check_eq("s1_p0_top", o_top[0], 0);
        check_eq("s1_p0_bot", o_bot[0], 1);
        check_eq("s1_p0_tw", o_tw[0], 0);
        check_eq("s1_p0_stg", o_stg[0], 0);
        check_eq("s1_s1j1_top", o_top[9], 1);
        check_eq("s1_s1j1_bot", o_bot[9], 3);
        check_eq("s1_s1j1_tw", o_tw[9], 4);
        check_eq("s1_s2j5_top", o_top[21], 9);
        check_eq("s1_s2j5_bot", o_bot[21], 13);
        check_eq("s1_s2j5_tw", o_tw[21], 2);
        check_eq("s1_s3j7_top", o_top[31], 7);
        check_eq("s1_s3j7_bot", o_bot[31], 15);
        check_eq("s1_s3j7_tw", o_tw[31], 7);

        // stall for 5 cycles after stage0 j=3 is issued
        clear_tally();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 50 && !(rd_valid === 1'b1 && o_valid == 4); k++) tick(1'b0, 1'b0, 1'b0);
        check_eq("s2_reach_top", rd_addr_top, 6);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            check_eq("s2_hold_valid", rd_valid, 0);
            check_eq("s2_hold_top", rd_addr_top, 6);
            check_eq("s2_hold_bot", rd_addr_bot, 7);
        end
        run_until_idle(150);
        n6 = 0;
        for (int i = 0; i < NP; i++) if (o_stg[i] == 0 && o_top[i] == 6) n6++;
        check_eq("s2_j3_once", n6, 1);
        check_eq("s2_nvalid", o_valid, NP);
        check_eq("s2_nnext", o_np, NP);
        check_eq("s2_ndone", o_done, 1);

        // reset at stage2 j=2, then a fresh transform
        clear_tally();
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 80 && !(rd_valid === 1'b1 && o_valid == 19); k++) tick(1'b0, 1'b0, 1'b0);
        check_eq("s3_reach_stage", stage, 2);
        check_eq("s3_reach_top", rd_addr_top, 2);
        clear_tally();
        tick(1'b0, 1'b0, 1'b1);
        check_eq("s3_rst_top", rd_addr_top, 0);
        check_eq("s3_rst_busy", busy, 0);
        for (int k = 0; k < 12; k++) tick(1'b0, 1'b0, 1'b0);
        check_eq("s3_no_done", o_done, 0);
        check_eq("s3_no_next", o_np, 0);
        clear_tally();
        tick(1'b1, 1'b0, 1'b0);
        run_until_idle(100);
        check_eq("s3_nvalid", o_valid, NP);
        check_eq("s3_ndone", o_done, 1);

        // start while busy is ignored
        clear_tally();
        t0 = cyc;
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        run_until_idle(100);
        check_eq("s4_nvalid", o_valid, NP);
        check_eq("s4_ndone", o_done, 1);

        // reset wins over a simultaneous start
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check_eq("rst_prio_busy", busy, 0);
        check_eq("rst_prio_valid", rd_valid, 0);

        // randomized stall and stray starts
        for (int r = 0; r < 6; r++) begin
            int idle_n;
            idle_n = $urandom_range(0, 3);
            for (int k = 0; k < idle_n; k++) tick(1'b0, 1'b0, 1'b0);
            clear_tally();
            tick(1'b1, ($urandom_range(0, 3) == 0), 1'b0);
            for (int k = 0; k < 400 && m_active; k++)
                tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0), 1'b0);
            check_eq("rnd_budget", {31'd0, m_active}, 32'd0);
            check_eq("rnd_nvalid", o_valid, NP);
            check_eq("rnd_ndone", o_done, 1);
        end
        tick(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
